// File: rtl/vending_machine_gen.sv
// vending_machine_gen
//   Parametrised vending controller. Accumulates credit from three coin
//   denominations and vends one of NUM_ITEMS products, each with its own
//   price. Change goes out as CHG_UNIT-valued beats over a valid/ready
//   handshake. A cancel request refunds the full credit.
//
//   Optional feature macro: VM_TIMEOUT_EN
//     When defined, an inactivity counter runs while credit is held. After
//     TIMEOUT_CYC idle cycles the machine refunds as if cancel were pressed
//     and pulses timeout for one cycle. When undefined, no counter is built
//     and timeout is a constant 0.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   coin_valid    coin inserted this cycle
//   coin_type     0/1/2 = COIN0/1/2 value, 3 = counterfeit
//   sel_valid     product selection strobe
//   sel_item      selected product index
//   cancel        refund request
//   chg_ready     change hopper accepts a beat
//   coin_reject   pulse: coin returned uncounted
//   sel_err       pulse: selection refused
//   vend_valid    pulse: dispense product
//   vend_item     product being dispensed (held until the next vend)
//   chg_valid     change beat pending
//   credit        current credit
//   busy          high while vending or returning change
//   timeout       pulse on auto-refund
module vending_machine_gen #(
  parameter int unsigned NUM_ITEMS   = 4,
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned COIN0_VAL   = 5,
  parameter int unsigned COIN1_VAL   = 10,
  parameter int unsigned COIN2_VAL   = 25,
  parameter int unsigned CHG_UNIT    = 5,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICE = {8'd50, 8'd35, 8'd20, 8'd15},
  parameter int unsigned MAX_CREDIT  = 100,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         coin_valid,
  input  logic [1:0]                   coin_type,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel_item,
  input  logic                         cancel,
  input  logic                         chg_ready,
  output logic                         coin_reject,
  output logic                         sel_err,
  output logic                         vend_valid,
  output logic [$clog2(NUM_ITEMS)-1:0] vend_item,
  output logic                         chg_valid,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         busy,
  output logic                         timeout
);

  localparam int unsigned SEL_W = $clog2(NUM_ITEMS);
  localparam logic [CREDIT_W-1:0] CHG = CREDIT_W'(CHG_UNIT);

  if (NUM_ITEMS < 2 || MAX_CREDIT > (2**CREDIT_W - 1) || TIMEOUT_CYC < 2) begin : g_param_check
    $error("vending_machine_gen: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t               r_state;
  logic [CREDIT_W-1:0]  r_credit;
  logic [SEL_W-1:0]     r_vend_item;
  logic                 r_coin_reject;
  logic                 r_sel_err;
  logic                 r_vend_valid;
  logic                 r_chg_valid;
  logic                 r_busy;
  logic                 r_timeout;

  logic [CREDIT_W-1:0]  w_coin_val;
  logic [CREDIT_W:0]    w_coin_sum;
  logic                 w_coin_ok;
  logic [CREDIT_W-1:0]  w_sel_price;
  logic                 w_sel_in_range;
  logic [CREDIT_W-1:0]  w_vend_price;
  logic [CREDIT_W-1:0]  w_remain;
  logic                 w_cancel_win;

  always_comb begin
    w_coin_val = '0;
    case (coin_type)
      2'd0:    w_coin_val = CREDIT_W'(COIN0_VAL);
      2'd1:    w_coin_val = CREDIT_W'(COIN1_VAL);
      2'd2:    w_coin_val = CREDIT_W'(COIN2_VAL);
      default: w_coin_val = '0;
    endcase
  end

  // Widened sum so an over-ceiling coin can never wrap into a small credit.
  assign w_coin_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_coin_ok  = (coin_type != 2'd3) && (w_coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  // Price lookups walk the table so an out-of-range index never slices
  // past the end of ITEM_PRICE when NUM_ITEMS is not a power of two.
  always_comb begin
    w_sel_price    = '0;
    w_sel_in_range = 1'b0;
    w_vend_price   = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (sel_item == SEL_W'(i)) begin
        w_sel_price    = ITEM_PRICE[i*CREDIT_W +: CREDIT_W];
        w_sel_in_range = 1'b1;
      end
      if (r_vend_item == SEL_W'(i))
        w_vend_price = ITEM_PRICE[i*CREDIT_W +: CREDIT_W];
    end
  end

  assign w_remain     = r_credit - w_vend_price;
  assign w_cancel_win = cancel && (r_state == S_CREDIT);

`ifdef VM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_fire;

  assign w_to_fire = (r_state == S_CREDIT) && !coin_valid && !sel_valid && !cancel &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_to_cnt <= '0;
    else if (r_state != S_CREDIT || coin_valid || sel_valid || cancel)
      r_to_cnt <= '0;
    else if (!w_to_fire)
      r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  logic w_to_fire;
  assign w_to_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_credit      <= '0;
      r_vend_item   <= '0;
      r_coin_reject <= 1'b0;
      r_sel_err     <= 1'b0;
      r_vend_valid  <= 1'b0;
      r_chg_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_coin_reject <= 1'b0;
      r_sel_err     <= 1'b0;
      r_vend_valid  <= 1'b0;
      r_timeout     <= 1'b0;
      case (r_state)
        S_IDLE, S_CREDIT: begin
          if (w_cancel_win) begin
            r_coin_reject <= coin_valid;
            r_state       <= S_CHANGE;
            r_chg_valid   <= 1'b1;
            r_busy        <= 1'b1;
          end else if (sel_valid) begin
            r_coin_reject <= coin_valid;
            if (r_state == S_IDLE || !w_sel_in_range || r_credit < w_sel_price) begin
              r_sel_err <= 1'b1;
            end else begin
              r_state      <= S_VEND;
              r_vend_valid <= 1'b1;
              r_vend_item  <= sel_item;
              r_busy       <= 1'b1;
            end
          end else if (coin_valid) begin
            if (w_coin_ok) begin
              r_credit <= w_coin_sum[CREDIT_W-1:0];
              r_state  <= S_CREDIT;
            end else begin
              r_coin_reject <= 1'b1;
            end
          end else if (w_to_fire) begin
            r_timeout   <= 1'b1;
            r_state     <= S_CHANGE;
            r_chg_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        // Price is deducted at the end of the vend cycle, using the
        // registered item so sel_item may change freely meanwhile.
        S_VEND: begin
          r_coin_reject <= coin_valid;
          r_sel_err     <= sel_valid;
          r_credit      <= w_remain;
          if (w_remain != '0) begin
            r_state     <= S_CHANGE;
            r_chg_valid <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_CHANGE: begin
          r_coin_reject <= coin_valid;
          r_sel_err     <= sel_valid;
          if (r_chg_valid && chg_ready) begin
            if (r_credit <= CHG) begin
              r_credit    <= '0;
              r_chg_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_credit <= r_credit - CHG;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign coin_reject = r_coin_reject;
  assign sel_err     = r_sel_err;
  assign vend_valid  = r_vend_valid;
  assign vend_item   = r_vend_item;
  assign chg_valid   = r_chg_valid;
  assign credit      = r_credit;
  assign busy        = r_busy;
  assign timeout     = r_timeout;

endmodule

// File: doc/vending_machine_gen.md
Name: vending_machine_gen

Overview:
- Parametrised successor to the team's fixed 3-state vending FSM.
- Accumulates credit from N configurable coin denominations and vends one of NUM_ITEMS products, each with its own price.
- Returns change as a stream of fixed-value change units over a valid/ready handshake.
- Supports cancel/refund; credit is visible to the front-panel display logic.

Parameters:
- NUM_ITEMS, 4, number of selectable products (>=2).
- CREDIT_W, 8, width of the credit and price arithmetic.
- COIN0_VAL, 5, value of coin_type 0.
- COIN1_VAL, 10, value of coin_type 1.
- COIN2_VAL, 25, value of coin_type 2.
- CHG_UNIT, 5, value of one change beat. All coin values and prices are integer multiples of it.
- ITEM_PRICE, {8'd50,8'd35,8'd20,8'd15}, packed NUM_ITEMS*CREDIT_W price table; item i occupies bits [i*CREDIT_W +: CREDIT_W].
- MAX_CREDIT, 100, credit ceiling; must be <= 2^CREDIT_W-1.
- TIMEOUT_CYC, 1000, inactivity limit; used only with VM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- coin_valid  in  1  coin inserted this cycle
- coin_type  in  2  0/1/2 = COIN0/1/2; 3 = counterfeit
- sel_valid  in  1  product selection strobe
- sel_item  in  $clog2(NUM_ITEMS)  selected product index
- cancel  in  1  refund request
- chg_ready  in  1  change hopper accepts a beat
- coin_reject  out  1  one-cycle pulse: coin returned uncounted
- sel_err  out  1  one-cycle pulse: selection refused
- vend_valid  out  1  one-cycle pulse: dispense product
- vend_item  out  $clog2(NUM_ITEMS)  product being dispensed; held until the next vend
- chg_valid  out  1  change beat pending
- credit  out  CREDIT_W  current credit
- busy  out  1  high in VEND or CHANGE
- timeout  out  1  one-cycle pulse on auto-refund; constant 0 without VM_TIMEOUT_EN

Behaviour:
- Outputs and timing
  - All outputs are registered.
  - Reset: state=IDLE; credit=0; all pulses, chg_valid and busy = 0; vend_item=0.
  - Reset mid-operation discards credit and pending change; no refund is issued.
- States
  - IDLE: credit==0.
  - CREDIT: credit>0, accepting coins.
  - VEND: single cycle.
  - CHANGE: draining change.
- Event priority per cycle in IDLE/CREDIT: cancel > sel_valid > coin_valid.
  - A coin presented the same cycle as a winning cancel or select is rejected (coin_reject=1).
  - A select that loses to cancel is ignored silently (no sel_err).
- Coin handling
  - An accepted coin increments credit at the clock edge; credit reflects it on the next cycle.
  - IDLE -> CREDIT on the first accepted coin.
  - Rejected, credit unchanged: coin_type==3; credit+value > MAX_CREDIT; any coin in VEND or CHANGE.
  - Sum computed at CREDIT_W+1 bits; no wrap.
- Select handling
  - Rejected with sel_err when: in IDLE; sel_item >= NUM_ITEMS; or credit < price[sel_item]. State is unchanged.
  - Otherwise -> VEND next cycle.
  - VEND cycle: vend_valid=1, vend_item=sel_item, credit <= credit - price.
  - After VEND: go to CHANGE if the remainder >0, else IDLE. Exact payment gives no change beat.
- Cancel
  - In CREDIT: -> CHANGE with the full credit.
  - In IDLE: no effect.
  - In VEND/CHANGE: ignored.
- CHANGE
  - chg_valid=1 while credit>0.
  - Each cycle with chg_valid&&chg_ready: credit -= CHG_UNIT.
  - When credit reaches 0: chg_valid drops the same edge, -> IDLE.
  - chg_ready low stalls indefinitely with credit held.
  - sel_valid in VEND/CHANGE: sel_err.

Optional Feature:
- Macro: VM_TIMEOUT_EN.
- Defined:
  - An inactivity counter runs in CREDIT. It is cleared by any coin_valid, sel_valid or cancel input, and on entry to CREDIT.
  - On reaching TIMEOUT_CYC-1: timeout pulses for one cycle and the block auto-refunds exactly as cancel.
- Undefined: no counter is built, the timeout output is tied 0, and credit is held indefinitely.

Test Plan:
- Exact payment: reset; coins 10,10 -> credit 20; select item1 (20) -> vend_valid 1 cycle with vend_item=1; credit=0; IDLE; no chg_valid.
- Change stream: coin 25, coin 25; select item0 (15) -> vend; credit=35; chg_ready=1 -> 7 beats of chg_valid; IDLE.
- Handshake stall: same flow with chg_ready toggling -> credit decrements only on ready cycles, with 7 accepted beats total.
- Rejects: coin_type=3 -> coin_reject, credit 0. Credit 95 + coin 10 -> reject, credit stays 95. Credit 10, select item3 (50) -> sel_err, credit 10. Select in IDLE -> sel_err.
- Priority: credit 30; cancel+sel+coin in the same cycle -> coin_reject; no sel_err; 6 change beats; no vend.
- Timeout/reset: with VM_TIMEOUT_EN and TIMEOUT_CYC=8, coin 5 then idle 8 cycles -> timeout pulse, 1 change beat. Async rst during CHANGE -> credit 0 and chg_valid 0 immediately.
